// File: rtl/fact_sched.sv
`default_nettype none
// ============================================================================
// Module   : fact_sched
// Summary  : Queues factorial jobs and dispatches them round-robin to four
//            register-mapped factorial units, returning tagged results.
//            Define FACT_SCHED_STATS_EN to enable issue/completion counters.
// Revision : 1.0
// ============================================================================
module fact_sched #(
  parameter int DEPTH  = 4,
  parameter int NUNITS = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [3:0]             job_n,
  input  logic [3:0]             job_tag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [3:0]             res_tag,
  output logic [31:0]            res_data,
  output logic [NUNITS-1:0]      fu_we,
  output logic [1:0]             fu_addr,
  output logic [31:0]            fu_wdata,
  input  logic [32*NUNITS-1:0]   fu_rdata,
  input  logic [NUNITS-1:0]      fu_done,
  output logic                   busy,
  output logic [15:0]            stat_issued,
  output logic [15:0]            stat_done
);

  localparam int            c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_N   = 3'd1,
    S_WR_GO  = 3'd2,
    S_RD_RES = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [1:0]         r_sel;
  logic [1:0]         w_sel_n;
  logic [1:0]         r_rr;
  logic [NUNITS-1:0]  r_occ;
  logic [3:0]         r_tag [NUNITS];

  logic [7:0]         r_fifo [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_AW:0]      r_count;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [3:0]         w_head_n;
  logic [3:0]         w_head_tag;

  logic               r_res_valid;
  logic [3:0]         r_res_tag;
  logic [31:0]        r_res_data;
  logic [31:0]        w_rd_slice;

  logic [NUNITS-1:0]  w_sel_oh;
  logic [NUNITS-1:0]  w_cmp_vec;
  logic               w_any_cmp;
  logic [1:0]         w_cmp_idx;
  logic               w_any_free;
  logic [1:0]         w_free_idx;
  logic               w_res_xfer;

  // ---------------------------------------------------------------- job FIFO
  assign w_empty   = (r_count == '0);
  assign job_ready = (r_count != c_FULL);
  assign w_push    = job_valid & job_ready;
  assign {w_head_n, w_head_tag} = r_fifo[r_rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {job_n, job_tag};
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------- unit selection
  assign w_cmp_vec  = r_occ & fu_done;
  assign w_sel_oh   = NUNITS'(1) << r_sel;
  assign w_rd_slice = fu_rdata[{r_sel, 5'b0} +: 32];

  always_comb begin
    w_any_cmp = 1'b0;
    w_cmp_idx = 2'd0;
    for (int i = NUNITS - 1; i >= 0; i--) begin
      if (w_cmp_vec[i]) begin
        w_any_cmp = 1'b1;
        w_cmp_idx = 2'(i);
      end
    end
  end

  // Walk backwards from rr+4 down to rr+1 so the nearest free unit wins.
  always_comb begin
    logic [1:0] v_cand;
    v_cand     = 2'd0;
    w_any_free = 1'b0;
    w_free_idx = 2'd0;
    for (int k = NUNITS; k >= 1; k--) begin
      v_cand = r_rr + 2'(k);
      if (!r_occ[v_cand]) begin
        w_any_free = 1'b1;
        w_free_idx = v_cand;
      end
    end
  end

  // ----------------------------------------------------------------- FSM
  always_comb begin
    w_state_n  = r_state;
    w_sel_n    = r_sel;
    fu_we      = '0;
    fu_addr    = 2'd0;
    fu_wdata   = 32'd0;
    w_pop      = 1'b0;
    w_res_xfer = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_cmp) begin
          w_sel_n   = w_cmp_idx;
          w_state_n = S_RD_RES;
        end else if (!w_empty && w_any_free) begin
          w_sel_n   = w_free_idx;
          w_state_n = S_WR_N;
        end
      end
      S_WR_N: begin
        fu_we     = w_sel_oh;
        fu_addr   = 2'd0;
        fu_wdata  = {28'd0, w_head_n};
        w_pop     = 1'b1;
        w_state_n = S_WR_GO;
      end
      S_WR_GO: begin
        fu_we     = w_sel_oh;
        fu_addr   = 2'd1;
        fu_wdata  = 32'd1;
        w_state_n = S_IDLE;
      end
      S_RD_RES: begin
        fu_addr   = 2'd3;
        w_state_n = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          // Writing GO=0 is what clears the unit's done level.
          fu_we      = w_sel_oh;
          fu_addr    = 2'd1;
          fu_wdata   = 32'd0;
          w_res_xfer = 1'b1;
          w_state_n  = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 2'd0;
      r_rr        <= 2'd3;
      r_occ       <= '0;
      r_res_valid <= 1'b0;
      r_res_tag   <= 4'd0;
      r_res_data  <= 32'd0;
      for (int i = 0; i < NUNITS; i++) begin
        r_tag[i] <= 4'd0;
      end
    end else begin
      r_state <= w_state_n;
      r_sel   <= w_sel_n;
      if (r_state == S_WR_N) begin
        r_rr         <= r_sel;
        r_tag[r_sel] <= w_head_tag;
      end
      if (r_state == S_WR_GO) begin
        r_occ[r_sel] <= 1'b1;
      end
      if (r_state == S_RD_RES) begin
        r_res_valid <= 1'b1;
        r_res_tag   <= r_tag[r_sel];
        r_res_data  <= w_rd_slice;
      end
      if (w_res_xfer) begin
        r_res_valid  <= 1'b0;
        r_occ[r_sel] <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_tag   = r_res_tag;
  assign res_data  = r_res_data;
  assign busy      = (|r_occ) | ~w_empty | (r_state != S_IDLE);

  // ------------------------------------------------------------ statistics
`ifdef FACT_SCHED_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_done;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stat_issued <= 16'd0;
      r_stat_done   <= 16'd0;
    end else begin
      if (r_state == S_WR_GO) begin
        r_stat_issued <= r_stat_issued + 16'd1;
      end
      if (w_res_xfer) begin
        r_stat_done <= r_stat_done + 16'd1;
      end
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_done   = r_stat_done;
`else
  assign stat_issued = 16'd0;
  assign stat_done   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fact_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fact_sched
// Summary  : Self-checking bench for fact_sched with behavioural factorial
//            units and a job-level reference model.
// Revision : 1.0
// ============================================================================
module tb_fact_sched;

  localparam int DEPTH = 4;
`ifdef FACT_SCHED_STATS_EN
  localparam bit c_STATS = 1'b1;
`else
  localparam bit c_STATS = 1'b0;
`endif

  logic         sys_clk   = 1'b0;
  logic         sys_rst   = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [3:0]   job_n     = 4'd0;
  logic [3:0]   job_tag   = 4'd0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [3:0]   res_tag;
  logic [31:0]  res_data;
  logic [3:0]   fu_we;
  logic [1:0]   fu_addr;
  logic [31:0]  fu_wdata;
  logic [127:0] fu_rdata;
  logic [3:0]   fu_done   = 4'd0;
  logic         busy;
  logic [15:0]  stat_issued;
  logic [15:0]  stat_done;

  always #5 sys_clk = ~sys_clk;

  fact_sched #(.DEPTH(DEPTH), .NUNITS(4)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_n       (job_n),
    .job_tag     (job_tag),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_tag     (res_tag),
    .res_data    (res_data),
    .fu_we       (fu_we),
    .fu_addr     (fu_addr),
    .fu_wdata    (fu_wdata),
    .fu_rdata    (fu_rdata),
    .fu_done     (fu_done),
    .busy        (busy),
    .stat_issued (stat_issued),
    .stat_done   (stat_done)
  );

  typedef struct packed {
    logic [3:0] n;
    logic [3:0] tag;
  } job_t;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural factorial units
  logic [31:0] u_res [4];
  logic [3:0]  u_n   [4];
  int          u_cnt [4];
  logic [3:0]  u_run;

  // Reference model of the scheduler at job level
  job_t        jobq[$];
  logic [3:0]  m_occ;
  int          m_last;
  logic [3:0]  m_tag [4];
  logic [3:0]  m_n   [4];
  int          expect_go_unit;
  int          exp_cmp_unit;
  logic [3:0]  elig_d1, elig_d2;
  logic        prev_hold, prev_rv;
  logic [31:0] prev_data;
  logic [3:0]  prev_tag;
  int          n_acc, n_done, n_go, s_go, s_done;
  int          step_no, acc_step, last_issue_step;
  logic [31:0] last_data;
  logic [3:0]  last_tag;
  logic        rec_first;
  logic [3:0]  first_we;
  logic [1:0]  first_addr;

  logic        drv_valid, drv_rready;
  logic [3:0]  drv_n, drv_tag;

  always_comb begin
    fu_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (fu_addr == 2'd3) fu_rdata[32*i +: 32] = u_res[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fact32(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick();
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (m_last + k) % 4;
      if (!m_occ[c]) return c;
    end
    return -1;
  endfunction

  task automatic fu_update();
    for (int i = 0; i < 4; i++) begin
      if (fu_we[i]) begin
        if (fu_addr == 2'd0) begin
          u_n[i]   = fu_wdata[3:0];
          u_cnt[i] = 0;
        end else if (fu_addr == 2'd1 && fu_wdata == 32'd1) begin
          u_cnt[i] = int'($urandom_range(1, 8));
        end
        fu_done[i] = 1'b0;
      end else if (u_cnt[i] > 0 && u_run[i]) begin
        u_cnt[i]--;
        if (u_cnt[i] == 0) begin
          u_res[i]   = fact32(int'(u_n[i]));
          fu_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic observe();
    int   u;
    int   exp_u;
    job_t j;
    logic busy_exp;
    step_no++;
    busy_exp = (m_occ != 4'd0) || (jobq.size() > 0) || (expect_go_unit >= 0);
    chk("job_ready", 32'(job_ready), 32'(jobq.size() < DEPTH));
    chk("busy", 32'(busy), 32'(busy_exp));
    chk("we_onehot0", 32'($onehot0(fu_we)), 32'd1);
    if (fu_we == 4'd0) begin
      chk("idle_wdata", fu_wdata, 32'd0);
      chk("idle_addr", 32'(fu_addr == 2'd0 || fu_addr == 2'd3), 32'd1);
    end
    if (prev_hold) begin
      chk("hold_data", res_data, prev_data);
      chk("hold_tag", 32'(res_tag), 32'(prev_tag));
    end
    if (res_valid && !res_ready) chk("hold_no_write", 32'(fu_we), 32'd0);
    if (res_valid && !prev_rv) begin
      chk("cmp_eligible", 32'(elig_d2 != 4'd0), 32'd1);
      exp_cmp_unit = lowest(elig_d2);
    end
    u = lowest(fu_we);
    if (rec_first && fu_we != 4'd0) begin
      first_we   = fu_we;
      first_addr = fu_addr;
      rec_first  = 1'b0;
    end
    if (expect_go_unit >= 0) begin
      chk("go_we", 32'(fu_we), 32'(4'b0001 << expect_go_unit));
      chk("go_addr", 32'(fu_addr), 32'd1);
      chk("go_wdata", fu_wdata, 32'd1);
      m_occ[expect_go_unit] = 1'b1;
      n_go++;
      s_go++;
      expect_go_unit = -1;
    end else if (fu_we != 4'd0 && fu_addr == 2'd0) begin
      exp_u = rr_pick();
      chk("issue_unit", 32'(u), 32'(exp_u));
      chk("issue_prio", 32'(elig_d1), 32'd0);
      chk("issue_has_job", 32'(jobq.size() > 0), 32'd1);
      if (jobq.size() > 0) begin
        j = jobq.pop_front();
        chk("issue_n", fu_wdata, {28'd0, j.n});
        m_n[u]   = j.n;
        m_tag[u] = j.tag;
      end
      m_last          = u;
      expect_go_unit  = u;
      last_issue_step = step_no;
    end else if (fu_we != 4'd0) begin
      chk("clr_addr", 32'(fu_addr), 32'd1);
      chk("clr_wdata", fu_wdata, 32'd0);
      chk("clr_xfer", 32'(res_valid && res_ready), 32'd1);
      chk("clr_was_done", 32'(m_occ[u] && fu_done[u]), 32'd1);
      chk("cmp_unit", 32'(u), 32'(exp_cmp_unit));
      chk("res_data", res_data, fact32(int'(m_n[u])));
      chk("res_tag", 32'(res_tag), 32'(m_tag[u]));
      last_data = res_data;
      last_tag  = res_tag;
      m_occ[u]  = 1'b0;
      n_done++;
      s_done++;
    end
    if (res_valid && res_ready) chk("xfer_has_clear", 32'($countones(fu_we)), 32'd1);
    if (job_valid && job_ready) begin
      j.n   = job_n;
      j.tag = job_tag;
      jobq.push_back(j);
      n_acc++;
      acc_step = step_no;
    end
    fu_update();
    prev_hold = res_valid && !res_ready;
    prev_data = res_data;
    prev_tag  = res_tag;
    prev_rv   = res_valid;
    elig_d2   = elig_d1;
    elig_d1   = m_occ & fu_done;
  endtask

  task automatic step();
    @(negedge sys_clk);
    job_valid = drv_valid;
    job_n     = drv_n;
    job_tag   = drv_tag;
    res_ready = drv_rready;
    #1;
    observe();
  endtask

  task automatic do_reset();
    sys_rst        = 1'b1;
    drv_valid      = 1'b0;
    drv_rready     = 1'b0;
    job_valid      = 1'b0;
    res_ready      = 1'b0;
    jobq.delete();
    m_occ          = 4'd0;
    m_last         = 3;
    expect_go_unit = -1;
    exp_cmp_unit   = -1;
    elig_d1        = 4'd0;
    elig_d2        = 4'd0;
    prev_hold      = 1'b0;
    prev_rv        = 1'b0;
    s_go           = 0;
    s_done         = 0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_fu_we", 32'(fu_we), 32'd0);
    chk("rst_fu_addr", 32'(fu_addr), 32'd0);
    chk("rst_fu_wdata", fu_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    drv_valid  = 1'b0;
    drv_rready = 1'b1;
    u_run      = 4'hF;
    while ((jobq.size() > 0 || m_occ != 4'd0 || expect_go_unit >= 0 || res_valid) && t < budget) begin
      step();
      t++;
    end
    chk("drained", 32'(jobq.size() == 0 && m_occ == 4'd0 && !res_valid), 32'd1);
  endtask

  task automatic submit(input logic [3:0] n, input logic [3:0] tag);
    drv_valid = 1'b1;
    drv_n     = n;
    drv_tag   = tag;
    step();
    drv_valid = 1'b0;
  endtask

  initial begin
    int t, base_done, base_go, base_acc;
    for (int i = 0; i < 4; i++) begin
      u_res[i] = 32'd0;
      u_n[i]   = 4'd0;
      u_cnt[i] = 0;
      m_tag[i] = 4'd0;
      m_n[i]   = 4'd0;
    end
    u_run = 4'hF;
    n_acc = 0; n_done = 0; n_go = 0; step_no = 0; acc_step = 0; last_issue_step = 0;
    rec_first = 1'b0; first_we = 4'd0; first_addr = 2'd0;
    last_data = 32'd0; last_tag = 4'd0;
    drv_n = 4'd0; drv_tag = 4'd0;

    // Reset state
    do_reset();
    #1;
    check_reset_outputs();
    chk("rst_stat_issued", 32'(stat_issued), 32'd0);
    chk("rst_stat_done", 32'(stat_done), 32'd0);

    // Single job n=5 tag=2 lands on unit 0, returns 120
    drv_rready = 1'b1;
    submit(4'd5, 4'd2);
    t = 0;
    while (last_issue_step <= acc_step && t < 10) begin step(); t++; end
    chk("issue_latency", 32'(last_issue_step - acc_step >= 1 && last_issue_step - acc_step <= 2), 32'd1);
    chk("first_unit", 32'(m_last), 32'd0);
    base_done = n_done;
    t = 0;
    while (n_done == base_done && t < 40) begin step(); t++; end
    chk("t1_done", 32'(n_done - base_done), 32'd1);
    chk("t1_data", last_data, 32'd120);
    chk("t1_tag", 32'(last_tag), 32'd2);

    // Back-to-back jobs with frozen units: fill all units and the queue
    do_reset();
    u_run    = 4'h0;
    base_acc = n_acc;
    drv_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drv_n   = 4'($urandom_range(0, 12));
      drv_tag = 4'($urandom);
      step();
    end
    drv_valid = 1'b0;
    step();
    chk("fill_accepted", 32'(n_acc - base_acc), 32'(4 + DEPTH));
    chk("fill_ready_low", 32'(job_ready), 32'd0);
    chk("fill_all_occ", 32'(m_occ), 32'hF);

    // Only unit 2 finishes: it must complete before the queued job issues
    u_run      = 4'b0100;
    drv_rready = 1'b1;
    rec_first  = 1'b1;
    base_done  = n_done;
    t = 0;
    while (n_done == base_done && t < 40) begin step(); t++; end
    chk("prio_first_we", 32'(first_we), 32'h4);
    chk("prio_first_addr", 32'(first_addr), 32'd1);
    drain(600);

    // Result held by a stalled consumer: no issue or completion meanwhile
    drv_rready = 1'b0;
    submit(4'd7, 4'd9);
    t = 0;
    while (!res_valid && t < 40) begin step(); t++; end
    chk("stall_valid_seen", 32'(res_valid), 32'd1);
    base_go   = n_go;
    base_done = n_done;
    drv_valid = 1'b1; drv_n = 4'd3; drv_tag = 4'd1;
    step(); step();
    drv_valid = 1'b0;
    repeat (8) step();
    chk("stall_no_issue", 32'(n_go - base_go), 32'd0);
    chk("stall_no_done", 32'(n_done - base_done), 32'd0);
    chk("stall_still_valid", 32'(res_valid), 32'd1);
    chk("stall_data", res_data, 32'd5040);
    drain(300);

    // Reset asserted during the GO write
    drv_rready = 1'b1;
    drv_valid  = 1'b1; drv_n = 4'd4; drv_tag = 4'd6;
    t = 0;
    while (expect_go_unit < 0 && t < 20) begin step(); drv_valid = 1'b0; t++; end
    chk("pre_rst_in_wrn", 32'(expect_go_unit >= 0), 32'd1);
    @(negedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check_reset_outputs();
    do_reset();
    base_done = n_done;
    drv_rready = 1'b1;
    repeat (15) step();
    chk("abandon_no_result", 32'(n_done - base_done), 32'd0);

    // Three complete jobs feed the statistics counters
    submit(4'd3, 4'd1);
    submit(4'd0, 4'd2);
    submit(4'd10, 4'd3);
    drain(300);
    chk("stats_go_seen", 32'(s_go), 32'd3);
    chk("stat_issued_3", 32'(stat_issued), c_STATS ? 32'(s_go) : 32'd0);
    chk("stat_done_3", 32'(stat_done), c_STATS ? 32'(s_done) : 32'd0);

    // Randomized traffic
    base_acc  = n_acc;
    base_done = n_done;
    for (int i = 0; i < 1500; i++) begin
      drv_valid  = 1'($urandom_range(0, 1));
      drv_n      = 4'($urandom);
      drv_tag    = 4'($urandom);
      drv_rready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(800);
    chk("rand_all_done", 32'(n_done - base_done), 32'(n_acc - base_acc));
    chk("stat_issued_end", 32'(stat_issued), c_STATS ? 32'(16'(s_go)) : 32'd0);
    chk("stat_done_end", 32'(stat_done), c_STATS ? 32'(16'(s_done)) : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
